// File: rtl/stop_watch_gen.sv
// BCD stopwatch core: prescaler tick, DIGITS-wide cascaded up/down BCD counter with wrap or saturate.
// Optional lap snapshot/freeze of the display is built only when STOP_WATCH_LAP_EN is defined.
module stop_watch_gen #(
  parameter int unsigned DIVISOR = 5_000_000,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned WRAP    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  clr,
  input  logic                  up,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   cnt,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  tick,
  output logic                  wrap,
  output logic                  lap_active
);

  localparam int unsigned PW = $clog2(DIVISOR);
  localparam logic [PW-1:0] PLAST = PW'(DIVISOR - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] cnt_q, cnt_d, step_val;
  logic                wrap_q, wrap_d;
  logic                sat_q, sat_d;
  logic                term, at_limit;
  logic                carry;
  logic [3:0]          digit;

  assign term = (presc_q == PLAST);
  assign tick = go & term & ~clr & ~reset;

  // Ripple carry/borrow through the digits; a carry out of the top digit means
  // every digit was at its extreme, i.e. the count sits at the limit.
  always_comb begin
    step_val = cnt_q;
    carry    = 1'b1;
    digit    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit = cnt_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (digit == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
    at_limit = carry;
  end

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (go) begin
      presc_d = term ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      if (!at_limit) begin
        cnt_d = step_val;
        sat_d = 1'b0;
      end else if (WRAP != 0) begin
        cnt_d  = step_val;
        wrap_d = 1'b1;
      end else if (!sat_q) begin
        // Saturated: pulse once, stay silent until the count leaves the limit.
        wrap_d = 1'b1;
        sat_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      presc_q <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

`ifdef STOP_WATCH_LAP_EN
  logic [4*DIGITS-1:0] snap_q;
  logic                lap_q;

  // Capture uses the pre-tick count, so a coincident tick still advances cnt.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      snap_q <= '0;
      lap_q  <= 1'b0;
    end else if (lap) begin
      if (!lap_q) begin
        snap_q <= cnt_q;
        lap_q  <= 1'b1;
      end else begin
        lap_q  <= 1'b0;
      end
    end
  end

  assign disp       = lap_q ? snap_q : cnt_q;
  assign lap_active = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = cnt_q;
  assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stop_watch_gen.sv
// Directed bench for stop_watch_gen: a WRAP=1 and a WRAP=0 instance share all inputs.
module tb_stop_watch_gen;

  logic        clk = 1'b0;
  logic        reset, go, clr, up, lap;
  logic [11:0] cnt_w, disp_w, cnt_s, disp_s;
  logic        tick_w, wrap_w, la_w, tick_s, wrap_s, la_s;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  stop_watch_gen #(.DIVISOR(4), .DIGITS(3), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .lap(lap),
    .cnt(cnt_w), .disp(disp_w), .tick(tick_w), .wrap(wrap_w), .lap_active(la_w)
  );

  stop_watch_gen #(.DIVISOR(4), .DIGITS(3), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .lap(lap),
    .cnt(cnt_s), .disp(disp_s), .tick(tick_s), .wrap(wrap_s), .lap_active(la_s)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; go = 1'b0; clr = 1'b0; up = 1'b1; lap = 1'b0;
    cyc(2);
    reset = 1'b0;
    if (cnt_w !== 12'h000) begin $display("FAIL reset.cnt_w got %h want 000", cnt_w); n_err++; end n_vec++;
    if (disp_w !== 12'h000) begin $display("FAIL reset.disp_w got %h want 000", disp_w); n_err++; end n_vec++;
    if (tick_w !== 1'b0) begin $display("FAIL reset.tick_w got %b want 0", tick_w); n_err++; end n_vec++;
    if (wrap_w !== 1'b0) begin $display("FAIL reset.wrap_w got %b want 0", wrap_w); n_err++; end n_vec++;
    if (la_w !== 1'b0) begin $display("FAIL reset.lap_active_w got %b want 0", la_w); n_err++; end n_vec++;
    if (cnt_s !== 12'h000) begin $display("FAIL reset.cnt_s got %h want 000", cnt_s); n_err++; end n_vec++;
  endtask

  task automatic test_free_run;
    logic exp_t;
    go = 1'b1; up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      exp_t = ((i % 4) == 3);
      if (tick_w !== exp_t) begin $display("FAIL free_run.tick cyc %0d got %b want %b", i, tick_w, exp_t); n_err++; end n_vec++;
      cyc(1);
    end
    if (cnt_w !== 12'h010) begin $display("FAIL free_run.cnt_w got %h want 010", cnt_w); n_err++; end n_vec++;
    if (disp_w !== 12'h010) begin $display("FAIL free_run.disp_w got %h want 010", disp_w); n_err++; end n_vec++;
    if (cnt_s !== 12'h010) begin $display("FAIL free_run.cnt_s got %h want 010", cnt_s); n_err++; end n_vec++;
    if (wrap_w !== 1'b0) begin $display("FAIL free_run.wrap_w got %b want 0", wrap_w); n_err++; end n_vec++;
    go = 1'b0;
  endtask

  task automatic test_pause;
    clr = 1'b1; cyc(1); clr = 1'b0;
    if (cnt_w !== 12'h000) begin $display("FAIL pause.clr_cnt got %h want 000", cnt_w); n_err++; end n_vec++;
    go = 1'b1; cyc(2);
    go = 1'b0; cyc(10);
    if (tick_w !== 1'b0) begin $display("FAIL pause.tick_paused got %b want 0", tick_w); n_err++; end n_vec++;
    if (cnt_w !== 12'h000) begin $display("FAIL pause.cnt_paused got %h want 000", cnt_w); n_err++; end n_vec++;
    go = 1'b1;
    cyc(1);
    if (tick_w !== 1'b1) begin $display("FAIL pause.tick_resume got %b want 1", tick_w); n_err++; end n_vec++;
    if (cnt_w !== 12'h000) begin $display("FAIL pause.cnt_before got %h want 000", cnt_w); n_err++; end n_vec++;
    cyc(1);
    if (cnt_w !== 12'h001) begin $display("FAIL pause.cnt_after got %h want 001", cnt_w); n_err++; end n_vec++;
    go = 1'b0;
  endtask

  task automatic test_wrap_up;
    clr = 1'b1; cyc(1); clr = 1'b0;
    go = 1'b1; up = 1'b1;
    cyc(3996);
    if (cnt_w !== 12'h999) begin $display("FAIL wrap_up.preload_w got %h want 999", cnt_w); n_err++; end n_vec++;
    if (cnt_s !== 12'h999) begin $display("FAIL wrap_up.preload_s got %h want 999", cnt_s); n_err++; end n_vec++;
    cyc(3);
    if (tick_w !== 1'b1) begin $display("FAIL wrap_up.tick got %b want 1", tick_w); n_err++; end n_vec++;
    cyc(1);
    if (cnt_w !== 12'h000) begin $display("FAIL wrap_up.cnt_w got %h want 000", cnt_w); n_err++; end n_vec++;
    if (wrap_w !== 1'b1) begin $display("FAIL wrap_up.wrap_w got %b want 1", wrap_w); n_err++; end n_vec++;
    if (cnt_s !== 12'h999) begin $display("FAIL wrap_up.cnt_s got %h want 999", cnt_s); n_err++; end n_vec++;
    if (wrap_s !== 1'b1) begin $display("FAIL wrap_up.wrap_s got %b want 1", wrap_s); n_err++; end n_vec++;
    cyc(1);
    if (wrap_w !== 1'b0) begin $display("FAIL wrap_up.wrap_w_pulse got %b want 0", wrap_w); n_err++; end n_vec++;
    if (wrap_s !== 1'b0) begin $display("FAIL wrap_up.wrap_s_pulse got %b want 0", wrap_s); n_err++; end n_vec++;
    cyc(3);
    if (cnt_s !== 12'h999) begin $display("FAIL wrap_up.sat_hold got %h want 999", cnt_s); n_err++; end n_vec++;
    if (wrap_s !== 1'b0) begin $display("FAIL wrap_up.sat_no_repulse got %b want 0", wrap_s); n_err++; end n_vec++;
    if (cnt_w !== 12'h001) begin $display("FAIL wrap_up.cnt_w_next got %h want 001", cnt_w); n_err++; end n_vec++;
    go = 1'b0;
  endtask

  task automatic test_down;
    clr = 1'b1; cyc(1); clr = 1'b0;
    go = 1'b1; up = 1'b1;
    cyc(400);
    if (cnt_w !== 12'h100) begin $display("FAIL down.preload got %h want 100", cnt_w); n_err++; end n_vec++;
    cyc(2);
    up = 1'b0;
    cyc(2);
    if (cnt_w !== 12'h099) begin $display("FAIL down.borrow_w got %h want 099", cnt_w); n_err++; end n_vec++;
    if (cnt_s !== 12'h099) begin $display("FAIL down.borrow_s got %h want 099", cnt_s); n_err++; end n_vec++;
    cyc(396);
    if (cnt_w !== 12'h000) begin $display("FAIL down.zero got %h want 000", cnt_w); n_err++; end n_vec++;
    cyc(4);
    if (cnt_w !== 12'h999) begin $display("FAIL down.wrap_cnt_w got %h want 999", cnt_w); n_err++; end n_vec++;
    if (wrap_w !== 1'b1) begin $display("FAIL down.wrap_w got %b want 1", wrap_w); n_err++; end n_vec++;
    if (cnt_s !== 12'h000) begin $display("FAIL down.sat_cnt_s got %h want 000", cnt_s); n_err++; end n_vec++;
    if (wrap_s !== 1'b1) begin $display("FAIL down.wrap_s got %b want 1", wrap_s); n_err++; end n_vec++;
    cyc(1);
    cyc(3);
    if (cnt_w !== 12'h998) begin $display("FAIL down.cnt_w_next got %h want 998", cnt_w); n_err++; end n_vec++;
    if (cnt_s !== 12'h000) begin $display("FAIL down.sat_hold got %h want 000", cnt_s); n_err++; end n_vec++;
    if (wrap_s !== 1'b0) begin $display("FAIL down.sat_no_repulse got %b want 0", wrap_s); n_err++; end n_vec++;
    go = 1'b0; up = 1'b1;
  endtask

  task automatic test_lap;
    clr = 1'b1; cyc(1); clr = 1'b0;
    go = 1'b1; up = 1'b1;
    cyc(48);
    if (cnt_w !== 12'h012) begin $display("FAIL lap.preload got %h want 012", cnt_w); n_err++; end n_vec++;
    lap = 1'b1; cyc(1); lap = 1'b0;
`ifdef STOP_WATCH_LAP_EN
    if (la_w !== 1'b1) begin $display("FAIL lap.active got %b want 1", la_w); n_err++; end n_vec++;
    if (disp_w !== 12'h012) begin $display("FAIL lap.disp_frozen got %h want 012", disp_w); n_err++; end n_vec++;
    cyc(12);
    if (cnt_w !== 12'h015) begin $display("FAIL lap.cnt_runs got %h want 015", cnt_w); n_err++; end n_vec++;
    if (disp_w !== 12'h012) begin $display("FAIL lap.disp_held got %h want 012", disp_w); n_err++; end n_vec++;
    lap = 1'b1; cyc(1); lap = 1'b0;
    if (la_w !== 1'b0) begin $display("FAIL lap.release got %b want 0", la_w); n_err++; end n_vec++;
    if (disp_w !== 12'h015) begin $display("FAIL lap.disp_live got %h want 015", disp_w); n_err++; end n_vec++;
    cyc(1);
    if (tick_w !== 1'b1) begin $display("FAIL lap.tick_align got %b want 1", tick_w); n_err++; end n_vec++;
    lap = 1'b1; cyc(1); lap = 1'b0;
    if (cnt_w !== 12'h016) begin $display("FAIL lap.tick_cnt got %h want 016", cnt_w); n_err++; end n_vec++;
    if (disp_w !== 12'h015) begin $display("FAIL lap.tick_snap got %h want 015", disp_w); n_err++; end n_vec++;
    if (la_w !== 1'b1) begin $display("FAIL lap.tick_active got %b want 1", la_w); n_err++; end n_vec++;
    lap = 1'b1; cyc(1); lap = 1'b0;
    if (la_w !== 1'b0) begin $display("FAIL lap.release2 got %b want 0", la_w); n_err++; end n_vec++;
`else
    if (la_w !== 1'b0) begin $display("FAIL lap.ignored got %b want 0", la_w); n_err++; end n_vec++;
    if (disp_w !== 12'h012) begin $display("FAIL lap.disp_live got %h want 012", disp_w); n_err++; end n_vec++;
    cyc(12);
    if (disp_w !== 12'h015) begin $display("FAIL lap.disp_follows got %h want 015", disp_w); n_err++; end n_vec++;
`endif
    go = 1'b0;
  endtask

  task automatic test_clr_priority;
    clr = 1'b1; cyc(1); clr = 1'b0;
    go = 1'b1; up = 1'b1;
    cyc(7);
    if (tick_w !== 1'b1) begin $display("FAIL clr.tick_align got %b want 1", tick_w); n_err++; end n_vec++;
    if (cnt_w !== 12'h001) begin $display("FAIL clr.pre_cnt got %h want 001", cnt_w); n_err++; end n_vec++;
    clr = 1'b1; lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    if (cnt_w !== 12'h000) begin $display("FAIL clr.cnt got %h want 000", cnt_w); n_err++; end n_vec++;
    if (disp_w !== 12'h000) begin $display("FAIL clr.disp got %h want 000", disp_w); n_err++; end n_vec++;
    if (la_w !== 1'b0) begin $display("FAIL clr.lap_active got %b want 0", la_w); n_err++; end n_vec++;
    if (wrap_w !== 1'b0) begin $display("FAIL clr.wrap got %b want 0", wrap_w); n_err++; end n_vec++;
    cyc(8);
    if (cnt_w !== 12'h000) begin $display("FAIL clr.held_cnt got %h want 000", cnt_w); n_err++; end n_vec++;
    if (tick_w !== 1'b0) begin $display("FAIL clr.held_tick got %b want 0", tick_w); n_err++; end n_vec++;
    clr = 1'b0;
    cyc(10);
    if (cnt_w !== 12'h002) begin $display("FAIL clr.recount got %h want 002", cnt_w); n_err++; end n_vec++;
    reset = 1'b1;
    cyc(1);
    if (cnt_w !== 12'h000) begin $display("FAIL rst_mid.cnt got %h want 000", cnt_w); n_err++; end n_vec++;
    if (disp_w !== 12'h000) begin $display("FAIL rst_mid.disp got %h want 000", disp_w); n_err++; end n_vec++;
    if (tick_w !== 1'b0) begin $display("FAIL rst_mid.tick got %b want 0", tick_w); n_err++; end n_vec++;
    if (wrap_w !== 1'b0) begin $display("FAIL rst_mid.wrap got %b want 0", wrap_w); n_err++; end n_vec++;
    if (la_w !== 1'b0) begin $display("FAIL rst_mid.lap_active got %b want 0", la_w); n_err++; end n_vec++;
    if (cnt_s !== 12'h000) begin $display("FAIL rst_mid.cnt_s got %h want 000", cnt_s); n_err++; end n_vec++;
    reset = 1'b0; go = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pause();
    test_wrap_up();
    test_down();
    test_lap();
    test_clr_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stop_watch_gen.md
# stop_watch_gen

Parametrised BCD stopwatch core: a prescaler generates a count tick every DIVISOR clocks, driving a DIGITS-wide cascaded BCD counter that counts up or down, wraps or saturates, and optionally freezes a lap snapshot for display. It sits between the button debouncers and the hex/7-seg display multiplexer. Each nibble of the display bus feeds one display digit.

## Interface

Parameters:
- DIVISOR, default 5_000_000: clock cycles per count tick (0.1 s at 50 MHz); must be ≥ 2.
- DIGITS, default 4: number of BCD digits, 1..8.
- WRAP, default 1: 1 = roll over at the count limit; 0 = saturate and stop at the limit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- go  in  1  level; counting runs while high and pauses while low.
- clr  in  1  level; synchronous clear of count, prescaler and lap state.
- up  in  1  direction: 1 = count up, 0 = count down.
- lap  in  1  single-cycle pulse; lap capture/release (only with STOP_WATCH_LAP_EN).
- cnt  out  4*DIGITS  live BCD count; nibble 0 is the least significant digit.
- disp  out  4*DIGITS  value shown on the display: the live count, or the lap snapshot while a lap is held.
- tick  out  1  one-cycle pulse on each prescaler terminal count.
- wrap  out  1  one-cycle pulse when the count rolls over or reaches its saturation limit.
- lap_active  out  1  high while the display is frozen on a snapshot.

## Operation

- Priority on each clock edge: reset > clr > lap > count.
- Reset and clr both force prescaler = 0, cnt = 0, snapshot = 0, lap_active = 0, tick = 0, wrap = 0.
  - clr held high keeps everything at 0 regardless of go.
- Prescaler behaviour:
  - Counts 0..DIVISOR-1 while go = 1.
  - Holds its value while go = 0, so a pause keeps the partial tick.
  - Returns to 0 after DIVISOR-1.
- tick is high in the cycle the prescaler equals DIVISOR-1 and go = 1.
- Count step on tick:
  - up = 1: digit 0 increments. A digit going from 9 to 0 carries into the next digit.
  - up = 0: digit 0 decrements. A digit going from 0 to 9 borrows from the next digit.
- Count limits:
  - Up limit is all nines (e.g. 9999); down limit is all zeros.
  - A tick at the limit with WRAP = 1: the count wraps (all nines → 0, or 0 → all nines) and wrap pulses.
  - A tick at the limit with WRAP = 0: the count holds at the limit and wrap pulses once. Further ticks leave the count unchanged and do not pulse wrap again until the count moves off the limit.
- The up input is sampled only on tick. Changing direction mid-interval does not reset the prescaler.
- Digits never leave the range 0–9. Illegal BCD states are unreachable from reset.

## Timing

- A tick in cycle N updates cnt at edge N+1; wrap is asserted in that same cycle N+1.
- go rising in cycle 0 from prescaler = 0: the first count change is visible DIVISOR cycles later.
- disp is registered:
  - Live mode: disp equals cnt with 0 cycles of extra delay (combinational select of the cnt register).
  - Lap mode: disp equals the snapshot.
- A lap pulse at edge E captures the value cnt has at edge E, not the post-tick value.
- A tick and a lap in the same cycle: the snapshot takes the pre-increment value and the count still increments.
- clr coincident with a tick or a lap: clr wins; no wrap pulse and no capture.
- Reset mid-count: all outputs read 0 in the cycle after the reset edge.
- Reset values of all outputs: cnt = 0, disp = 0, tick = 0, wrap = 0, lap_active = 0.

## Configuration

- Macro: STOP_WATCH_LAP_EN.
- Defined:
  - A lap pulse while lap_active = 0 captures cnt into the snapshot and sets lap_active.
  - A lap pulse while lap_active = 1 clears lap_active, so disp returns to the live count.
  - Counting continues throughout.
- Undefined:
  - The lap input is ignored and no snapshot register is built.
  - disp = cnt and lap_active is tied to 0.

## Test plan

Bench settings: DIVISOR = 4, DIGITS = 3.

- **Free run, up:** reset, then go = 1 and up = 1 for 40 cycles → cnt = 0x010 after 40 cycles; tick pulses every 4th cycle.
- **Pause keeps partial tick:** go high for 2 cycles, low for 10, high again → the first increment lands 2 cycles after go re-rises; cnt = 0x001.
- **Wrap and saturate, up:** preload to 999 via counting, then one more tick.
  - WRAP = 1 → cnt = 0x000 and wrap pulses for 1 cycle.
  - WRAP = 0 → cnt stays 0x999, wrap pulses once, and a further tick gives no pulse.
- **Down count and borrow:** from cnt = 0x100 with up = 0, one tick → cnt = 0x099. From 0x000 with WRAP = 1 → cnt = 0x999 and wrap pulses.
- **Lap (macro defined):**
  - At cnt = 0x012, pulse lap → disp holds 0x012 and lap_active = 1, while cnt keeps advancing to 0x015.
  - A second lap pulse → disp = cnt and lap_active = 0.
  - lap coincident with a tick → snapshot holds the pre-tick value.
- **Clear and reset priority:** clr asserted with a tick and a lap in the same cycle → cnt = 0, disp = 0, lap_active = 0, wrap = 0. Reset asserted mid-count with go = 1 → all outputs 0 on the next cycle.
